// File: rtl/cache_pkg.sv
// cache_pkg: shared types and size helpers for the cache data array
//   op_e    : request opcodes (byte/word read/write)
//   state_e : sweep controller states
//   word_w/depth/lane_w : derived widths from the array parameters
package cache_pkg;
   typedef enum logic [1:0] {
      OP_RD_BYTE = 2'b00,
      OP_WR_BYTE = 2'b01,
      OP_RD_WORD = 2'b10,
      OP_WR_WORD = 2'b11
   } op_e;
   typedef enum logic {S_INVAL, S_IDLE} state_e;
   function automatic int word_w(int data_w, int bytes);
      return data_w * bytes;
   endfunction
   function automatic int depth(int index_w);
      return 1 << index_w;
   endfunction
   function automatic int lane_w(int bytes);
      return bytes > 1 ? $clog2(bytes) : 1;
   endfunction
endpackage

// File: rtl/cache_data_array_if.sv
// cache_data_array_if: request/response/invalidate bundle of the cache data array
//   master (controller): drives req_*, inv_start; sees req_ready, rsp_*, inv_busy
//   slave  (array)     : the reverse
interface cache_data_array_if
   import cache_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int BYTES   = 4,
   parameter int INDEX_W = 8
) ();
   localparam int WORD_W = word_w(DATA_W, BYTES);
   localparam int LANE_W = lane_w(BYTES);
   logic               req_valid;
   logic               req_ready;
   logic [1:0]         req_op;
   logic [INDEX_W-1:0] req_index;
   logic [LANE_W-1:0]  req_byte;
   logic [BYTES-1:0]   req_be;
   logic [WORD_W-1:0]  req_wdata;
   logic               rsp_valid;
   logic               rsp_hit;
   logic [WORD_W-1:0]  rsp_data;
   logic               inv_start;
   logic               inv_busy;
   modport master (
      output req_valid, req_op, req_index, req_byte, req_be, req_wdata, inv_start,
      input  req_ready, rsp_valid, rsp_hit, rsp_data, inv_busy
   );
   modport slave (
      input  req_valid, req_op, req_index, req_byte, req_be, req_wdata, inv_start,
      output req_ready, rsp_valid, rsp_hit, rsp_data, inv_busy
   );
endinterface

// File: rtl/cache_lane_ram.sv
// cache_lane_ram: one byte lane of the data store, DEPTH x DATA_W
//   clk   : clock
//   we    : write addr with wdata
//   re    : load rdata from addr (held until the next re)
//   addr  : word index
//   wdata : write byte
//   rdata : registered read byte
module cache_lane_ram #(
   parameter int DATA_W  = 8,
   parameter int INDEX_W = 8
) (
   input  logic               clk,
   input  logic               we,
   input  logic               re,
   input  logic [INDEX_W-1:0] addr,
   input  logic [DATA_W-1:0]  wdata,
   output logic [DATA_W-1:0]  rdata
);
   logic [DATA_W-1:0] mem [2**INDEX_W];
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      if (re) rdata <= mem[addr];
   end
endmodule

// File: rtl/cache_data_array.sv
// cache_data_array: valid-tagged byte-lane cache data store with invalidate sweep
//   clk   : clock
//   rst_n : asynchronous active-low reset (restarts the invalidate sweep)
//   bus   : cache_data_array_if.slave -- request, read response, invalidate control
module cache_data_array
   import cache_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int BYTES   = 4,
   parameter int INDEX_W = 8
) (
   input logic              clk,
   input logic              rst_n,
   cache_data_array_if.slave bus
);
   localparam int WORD_W = word_w(DATA_W, BYTES);
   localparam int DEPTH  = depth(INDEX_W);
   localparam int LANE_W = lane_w(BYTES);
   state_e             state, state_nx;
   logic [INDEX_W-1:0] ptr;
   logic [DEPTH-1:0]   valid;
   op_e                op;
   logic               acc, is_wr, is_byte;
   logic               hit_q, byte_q;
   logic [LANE_W-1:0]  lane_q;
   logic [DATA_W-1:0]  lane_rd [BYTES];
   logic [WORD_W-1:0]  word_rd;
   assign op      = op_e'(bus.req_op);
   assign acc     = bus.req_valid & bus.req_ready;
   assign is_wr   = op == OP_WR_BYTE || op == OP_WR_WORD;
   assign is_byte = op == OP_RD_BYTE || op == OP_WR_BYTE;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_INVAL;
         ptr   <= '0;
      end else begin
         state <= state_nx;
         ptr   <= state == S_INVAL ? ptr + 1'b1 : '0;
      end
   end
   // A request accepted together with inv_start is still served: the sweep
   // only starts on the following cycle, after the request's edge.
   always_comb begin
      state_nx = state == S_INVAL ? (&ptr ? S_IDLE : S_INVAL)
                                  : (bus.inv_start ? S_INVAL : S_IDLE);
   end
   always_comb begin
      bus.req_ready = state == S_IDLE;
      bus.inv_busy  = state == S_INVAL;
   end
   always_ff @(posedge clk) begin
      if (state == S_INVAL) valid[ptr] <= 1'b0;
      else if (acc && is_wr) valid[bus.req_index] <= 1'b1;
   end
   // Read context is captured only on read accept so the response holds
   // until the next read; hit_q gates the otherwise unreset lane outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rsp_valid <= 1'b0;
         hit_q         <= 1'b0;
         byte_q        <= 1'b0;
         lane_q        <= '0;
      end else begin
         bus.rsp_valid <= acc & ~is_wr;
         if (acc && !is_wr) begin
            hit_q  <= valid[bus.req_index];
            byte_q <= is_byte;
            lane_q <= bus.req_byte;
         end
      end
   end
   for (genvar g = 0; g < BYTES; g++) begin : g_lane
      logic              we;
      logic [DATA_W-1:0] wd;
      assign we = acc & is_wr & (is_byte ? bus.req_byte == LANE_W'(g) : bus.req_be[g]);
      assign wd = is_byte ? bus.req_wdata[DATA_W-1:0] : bus.req_wdata[g*DATA_W +: DATA_W];
      assign word_rd[g*DATA_W +: DATA_W] = lane_rd[g];
      cache_lane_ram #(.DATA_W(DATA_W), .INDEX_W(INDEX_W)) u_ram (
         .clk   (clk),
         .we    (we),
         .re    (acc & ~is_wr),
         .addr  (bus.req_index),
         .wdata (wd),
         .rdata (lane_rd[g])
      );
   end
   always_comb begin
      bus.rsp_hit  = hit_q;
      bus.rsp_data = !hit_q ? '0 : byte_q ? WORD_W'(lane_rd[lane_q]) : word_rd;
   end
endmodule
